// File: rtl/video_cleaner_sync.sv
// ---------------------------------------------------------------------------
// video_cleaner_sync
//
// Video output cleaner sitting between the video generator and the
// scaler/HDMI output. On every ce_pix it registers colour and timing, learns
// the native polarity of HSync and VSync, re-times VBlank/VSync changes to the
// HSync leading edge, and produces a data enable that optionally blanks the
// colour outputs outside active video. Every output lags its input by exactly
// one ce_pix cycle.
//
// Ports:
//   clk_vid, reset_n        video clock, asynchronous active-low reset
//   ce_pix                  pixel clock enable; no state changes while low
//   R, G, B                 input colour components (CW bits each)
//   HSync, VSync            raw syncs of either polarity
//   HBlank, VBlank          active-high blanks
//   DE_in                   external data enable (used when USE_DE=1)
//   VGA_R, VGA_G, VGA_B     cleaned colour
//   VGA_HS, VGA_VS          normalised syncs, active-low when SYNC_OUT_NEG=1
//   VGA_DE, DE_out          data enable (identical)
//   HBlank_out, VBlank_out  registered HBlank, line-aligned VBlank
//   hs_pol, vs_pol          learned input polarity (1 = input active-low)
// ---------------------------------------------------------------------------
module video_cleaner_sync #(
    parameter int CW           = 8,
    parameter int HCNT_W       = 12,
    parameter int VCNT_W       = 20,
    parameter int USE_DE       = 0,
    parameter int BLANK_ZERO   = 1,
    parameter int SYNC_OUT_NEG = 1
) (
    input  logic          clk_vid,
    input  logic          reset_n,
    input  logic          ce_pix,
    input  logic [CW-1:0] R,
    input  logic [CW-1:0] G,
    input  logic [CW-1:0] B,
    input  logic          HSync,
    input  logic          VSync,
    input  logic          HBlank,
    input  logic          VBlank,
    input  logic          DE_in,
    output logic [CW-1:0] VGA_R,
    output logic [CW-1:0] VGA_G,
    output logic [CW-1:0] VGA_B,
    output logic          VGA_HS,
    output logic          VGA_VS,
    output logic          VGA_DE,
    output logic          HBlank_out,
    output logic          VBlank_out,
    output logic          DE_out,
    output logic          hs_pol,
    output logic          vs_pol
);

    localparam logic              SYNC_NEG = (SYNC_OUT_NEG != 0);
    localparam logic              DE_PASS  = (USE_DE != 0);
    localparam logic              ZERO_BLK = (BLANK_ZERO != 0);
    localparam logic [HCNT_W-1:0] HCNT_ONE = HCNT_W'(1);
    localparam logic [VCNT_W-1:0] VCNT_ONE = VCNT_W'(1);

    // Polarity detection state
    logic              hs_prev_q, hs_prev_d;
    logic              vs_prev_q, vs_prev_d;
    logic [HCNT_W-1:0] hcnt_hi_q, hcnt_hi_d;
    logic [HCNT_W-1:0] hcnt_lo_q, hcnt_lo_d;
    logic [VCNT_W-1:0] vcnt_hi_q, vcnt_hi_d;
    logic [VCNT_W-1:0] vcnt_lo_q, vcnt_lo_d;
    logic              hs_pol_q, hs_pol_d;
    logic              vs_pol_q, vs_pol_d;

    // Line alignment state
    logic              hs_n_prev_q, hs_n_prev_d;
    logic              vs_a_q, vs_a_d;
    logic              vblank_q, vblank_d;

    // Output registers
    logic              hblank_q, hblank_d;
    logic              de_q, de_d;
    logic              vga_hs_q, vga_hs_d;
    logic              vga_vs_q, vga_vs_d;
    logic [CW-1:0]     r_q, r_d;
    logic [CW-1:0]     g_q, g_d;
    logic [CW-1:0]     b_q, b_d;

    logic              hs_n, vs_n, hs_lead;

    always_comb begin
        // Normalise with the polarity currently held; a polarity learned this
        // cycle only affects the next ce_pix.
        hs_n    = HSync ^ hs_pol_q;
        vs_n    = VSync ^ vs_pol_q;
        hs_lead = hs_n & ~hs_n_prev_q;

        hs_prev_d   = HSync;
        vs_prev_d   = VSync;
        hs_n_prev_d = hs_n;
        hs_pol_d    = hs_pol_q;
        vs_pol_d    = vs_pol_q;
        hcnt_hi_d   = hcnt_hi_q;
        hcnt_lo_d   = hcnt_lo_q;
        vcnt_hi_d   = vcnt_hi_q;
        vcnt_lo_d   = vcnt_lo_q;

        // HSync: the level that lasted longer over the previous period is the
        // inactive level. On a rising edge the verdict uses the old counts,
        // then counting restarts with the current (high) sample.
        if (HSync && !hs_prev_q) begin
            hs_pol_d  = (hcnt_hi_q > hcnt_lo_q);
            hcnt_hi_d = HCNT_ONE;
            hcnt_lo_d = '0;
        end else if (HSync) begin
            if (hcnt_hi_q != '1) hcnt_hi_d = hcnt_hi_q + HCNT_ONE;
        end else begin
            if (hcnt_lo_q != '1) hcnt_lo_d = hcnt_lo_q + HCNT_ONE;
        end

        // VSync: same scheme over a frame.
        if (VSync && !vs_prev_q) begin
            vs_pol_d  = (vcnt_hi_q > vcnt_lo_q);
            vcnt_hi_d = VCNT_ONE;
            vcnt_lo_d = '0;
        end else if (VSync) begin
            if (vcnt_hi_q != '1) vcnt_hi_d = vcnt_hi_q + VCNT_ONE;
        end else begin
            if (vcnt_lo_q != '1) vcnt_lo_d = vcnt_lo_q + VCNT_ONE;
        end

        // Vertical timing only moves on the HSync leading edge so that a
        // mid-line VBlank/VSync change lands together with the next HS pulse.
        vblank_d = hs_lead ? VBlank : vblank_q;
        vs_a_d   = hs_lead ? vs_n   : vs_a_q;

        hblank_d = HBlank;
        vga_hs_d = hs_n   ^ SYNC_NEG;
        vga_vs_d = vs_a_d ^ SYNC_NEG;

        de_d = DE_PASS ? DE_in : ~(HBlank | vblank_d);

        if (ZERO_BLK && !de_d) begin
            r_d = '0;
            g_d = '0;
            b_d = '0;
        end else begin
            r_d = R;
            g_d = G;
            b_d = B;
        end
    end

    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            hs_prev_q   <= 1'b0;
            vs_prev_q   <= 1'b0;
            hcnt_hi_q   <= '0;
            hcnt_lo_q   <= '0;
            vcnt_hi_q   <= '0;
            vcnt_lo_q   <= '0;
            hs_pol_q    <= 1'b0;
            vs_pol_q    <= 1'b0;
            hs_n_prev_q <= 1'b0;
            vs_a_q      <= 1'b0;
            vblank_q    <= 1'b1;
            hblank_q    <= 1'b1;
            de_q        <= 1'b0;
            vga_hs_q    <= SYNC_NEG;
            vga_vs_q    <= SYNC_NEG;
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
        end else if (ce_pix) begin
            hs_prev_q   <= hs_prev_d;
            vs_prev_q   <= vs_prev_d;
            hcnt_hi_q   <= hcnt_hi_d;
            hcnt_lo_q   <= hcnt_lo_d;
            vcnt_hi_q   <= vcnt_hi_d;
            vcnt_lo_q   <= vcnt_lo_d;
            hs_pol_q    <= hs_pol_d;
            vs_pol_q    <= vs_pol_d;
            hs_n_prev_q <= hs_n_prev_d;
            vs_a_q      <= vs_a_d;
            vblank_q    <= vblank_d;
            hblank_q    <= hblank_d;
            de_q        <= de_d;
            vga_hs_q    <= vga_hs_d;
            vga_vs_q    <= vga_vs_d;
            r_q         <= r_d;
            g_q         <= g_d;
            b_q         <= b_d;
        end
    end

    assign VGA_R      = r_q;
    assign VGA_G      = g_q;
    assign VGA_B      = b_q;
    assign VGA_HS     = vga_hs_q;
    assign VGA_VS     = vga_vs_q;
    assign VGA_DE     = de_q;
    assign DE_out     = de_q;
    assign HBlank_out = hblank_q;
    assign VBlank_out = vblank_q;
    assign hs_pol     = hs_pol_q;
    assign vs_pol     = vs_pol_q;

endmodule

// File: tb/tb_video_cleaner_sync.sv
// ---------------------------------------------------------------------------
// Bench for video_cleaner_sync. Two instances share the inputs: u_dut uses the
// default parameters (derived DE, blank zeroing), u_dut2 passes DE_in through
// and keeps colour during blanking. Stimulus pushes expected responses into a
// queue; the monitor pops one entry per checked clock edge.
// ---------------------------------------------------------------------------
module tb_video_cleaner_sync;

    logic       clk_vid = 1'b0;
    logic       reset_n = 1'b0;
    logic       ce_pix  = 1'b0;
    logic       chk_idle = 1'b0;
    logic [7:0] R = '0, G = '0, B = '0;
    logic       HSync = 1'b0, VSync = 1'b0, HBlank = 1'b0, VBlank = 1'b0, DE_in = 1'b0;

    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       VGA_HS, VGA_VS, VGA_DE, HBlank_out, VBlank_out, DE_out, hs_pol, vs_pol;
    logic [7:0] VGA_R2, VGA_G2, VGA_B2;
    logic       VGA_HS2, VGA_VS2, VGA_DE2, HBlank_out2, VBlank_out2, DE_out2, hs_pol2, vs_pol2;

    video_cleaner_sync u_dut (
        .clk_vid(clk_vid), .reset_n(reset_n), .ce_pix(ce_pix),
        .R(R), .G(G), .B(B), .HSync(HSync), .VSync(VSync),
        .HBlank(HBlank), .VBlank(VBlank), .DE_in(DE_in),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_DE(VGA_DE),
        .HBlank_out(HBlank_out), .VBlank_out(VBlank_out), .DE_out(DE_out),
        .hs_pol(hs_pol), .vs_pol(vs_pol)
    );

    video_cleaner_sync #(.USE_DE(1), .BLANK_ZERO(0)) u_dut2 (
        .clk_vid(clk_vid), .reset_n(reset_n), .ce_pix(ce_pix),
        .R(R), .G(G), .B(B), .HSync(HSync), .VSync(VSync),
        .HBlank(HBlank), .VBlank(VBlank), .DE_in(DE_in),
        .VGA_R(VGA_R2), .VGA_G(VGA_G2), .VGA_B(VGA_B2),
        .VGA_HS(VGA_HS2), .VGA_VS(VGA_VS2), .VGA_DE(VGA_DE2),
        .HBlank_out(HBlank_out2), .VBlank_out(VBlank_out2), .DE_out(DE_out2),
        .hs_pol(hs_pol2), .vs_pol(vs_pol2)
    );

    always #5 clk_vid = ~clk_vid;

    typedef struct {
        logic        full;   // check the state-dependent outputs of u_dut
        logic        pt;     // check hs_pol against ptv
        logic        ptv;
        logic [23:0] rgb;
        logic        hs, vs, hb, vb, de, hpol, vpol;
        logic [23:0] rgb2;
        logic        de2;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- monitor ----------------
    logic en_s;
    exp_t me;
    always @(posedge clk_vid) begin
        en_s = ce_pix | chk_idle;
        #1;
        if (en_s) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                me = sb.pop_front();
                if (me.full) begin
                    chk("rgb",        {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, me.rgb});
                    chk("vga_hs",     VGA_HS,     me.hs);
                    chk("vga_vs",     VGA_VS,     me.vs);
                    chk("vblank_out", VBlank_out, me.vb);
                    chk("de_out",     DE_out,     me.de);
                    chk("vga_de",     VGA_DE,     me.de);
                    chk("hs_pol",     hs_pol,     me.hpol);
                    chk("vs_pol",     vs_pol,     me.vpol);
                    chk("vga_hs2",    VGA_HS2,    me.hs);
                end
                if (me.pt) chk("hs_pol_learn", hs_pol, me.ptv);
                chk("hblank_out", HBlank_out, me.hb);
                chk("rgb2",       {8'h0, VGA_R2, VGA_G2, VGA_B2}, {8'h0, me.rgb2});
                chk("de_out2",    DE_out2,    me.de2);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic push_reset_exp();
        exp_t e;
        e.full = 1'b1; e.pt = 1'b0; e.ptv = 1'b0;
        e.rgb = 24'h0; e.hs = 1'b1; e.vs = 1'b1; e.hb = 1'b1; e.vb = 1'b1;
        e.de = 1'b0; e.hpol = 1'b0; e.vpol = 1'b0;
        e.rgb2 = 24'h0; e.de2 = 1'b0;
        sb.push_back(e);
    endtask

    // One 800-pixel line: sync pulse on pixels 0..95, HBlank on 700..799
    // (colour forced to FF there), VBlank/VSync level vb_lvl, optionally
    // rising at pixel 300. Expected values assume the polarity is already
    // learned (full=1). gap = idle clocks between pixels; rst_at = pixel at
    // which reset is asserted asynchronously (-1 = none).
    task automatic run_line(input bit act_low, input bit full, input bit vb_lvl,
                            input bit vb_rise, input int pt, input int gap,
                            input int rst_at);
        exp_t       e;
        logic [7:0] pb;
        logic       pulse, hb, vbin;
        logic [23:0] pix;
        for (int p = 0; p < 800; p++) begin
            @(negedge clk_vid);
            chk_idle = 1'b0;
            if (p == rst_at) begin
                ce_pix  = 1'b0;
                reset_n = 1'b0;
                #1;
                chk("rst_async_dut",  {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_DE, HBlank_out,
                                       VBlank_out, DE_out, hs_pol, vs_pol}, 32'h0000_00D8);
                chk("rst_async_dut2", {VGA_R2, VGA_G2, VGA_B2, VGA_HS2, VGA_VS2, VGA_DE2, HBlank_out2,
                                       VBlank_out2, DE_out2, hs_pol2, vs_pol2}, 32'h0000_00D8);
                repeat (3) @(negedge clk_vid);
                reset_n = 1'b1;
                return;
            end
            pb    = 8'(p);
            pulse = (p < 96);
            hb    = (p >= 700);
            vbin  = vb_lvl | (vb_rise && p >= 300);
            pix   = hb ? 24'hFFFFFF : {pb, ~pb, 8'h3C};
            HSync  = act_low ? ~pulse : pulse;
            VSync  = vbin;
            VBlank = vbin;
            HBlank = hb;
            {R, G, B} = pix;
            DE_in  = pb[0];
            ce_pix = 1'b1;

            e.full = full;
            e.pt   = (p == pt) || (p == pt - 1);
            e.ptv  = (p == pt) ? act_low : ~act_low;
            e.hs   = ~pulse;
            e.vs   = ~vb_lvl;
            e.hb   = hb;
            e.vb   = vb_lvl;
            e.de   = ~(hb | vb_lvl);
            e.rgb  = e.de ? pix : 24'h0;
            e.hpol = act_low;
            e.vpol = 1'b0;
            e.rgb2 = pix;
            e.de2  = pb[0];
            sb.push_back(e);

            // Idle clocks: scramble every input; outputs must not move.
            repeat (gap) begin
                @(negedge clk_vid);
                ce_pix   = 1'b0;
                chk_idle = 1'b1;
                R = 8'($urandom); G = 8'($urandom); B = 8'($urandom);
                HSync = ~HSync; VSync = ~VSync; HBlank = ~HBlank;
                VBlank = ~VBlank; DE_in = ~DE_in;
                sb.push_back(e);
            end
        end
    endtask

    initial begin
        exp_t e;

        // Reset held with random inputs.
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_vid);
            R = 8'($urandom); G = 8'($urandom); B = 8'($urandom);
            {HSync, VSync, HBlank, VBlank, DE_in} = 5'($urandom);
            ce_pix = 1'b1;
            push_reset_exp();
        end

        // First pixel after release.
        @(negedge clk_vid);
        reset_n = 1'b1;
        R = 8'h5A; G = 8'h11; B = 8'h22;
        HSync = 1'b1; VSync = 1'b0; HBlank = 1'b0; VBlank = 1'b0; DE_in = 1'b0;
        ce_pix = 1'b1;
        e.full = 1'b1; e.pt = 1'b0; e.ptv = 1'b0;
        e.rgb = 24'h5A1122; e.hs = 1'b0; e.vs = 1'b1; e.hb = 1'b0; e.vb = 1'b0;
        e.de = 1'b1; e.hpol = 1'b0; e.vpol = 1'b0; e.rgb2 = 24'h5A1122; e.de2 = 1'b0;
        sb.push_back(e);

        // Active-low HSync: polarity flips to 1 at pixel 96 of the second line.
        run_line(1, 0, 0, 0, -1,  0, -1);
        run_line(1, 0, 0, 0, 96,  0, -1);
        run_line(1, 1, 0, 0, -1,  0, -1);
        run_line(1, 1, 0, 0, -1,  0, -1);

        // Active-high HSync: polarity returns to 0 at pixel 0 of the third line.
        run_line(0, 0, 0, 0, -1,  0, -1);
        run_line(0, 0, 0, 0, -1,  0, -1);
        run_line(0, 0, 0, 0,  0,  0, -1);
        run_line(0, 1, 0, 0, -1,  0, -1);
        run_line(0, 1, 0, 0, -1,  0, -1);

        // ce_pix asserted on every 4th clock.
        run_line(0, 1, 0, 0, -1,  3, -1);

        // VBlank/VSync rise mid-line, take effect on the next line.
        run_line(0, 1, 0, 0, -1,  0, -1);
        run_line(0, 1, 0, 1, -1,  0, -1);
        run_line(0, 1, 1, 0, -1,  0, -1);
        run_line(0, 1, 0, 0, -1,  0, -1);

        // Active-low again, then reset mid-line and relearn.
        run_line(1, 0, 0, 0, -1,  0, -1);
        run_line(1, 0, 0, 0, -1,  0, -1);
        run_line(1, 1, 0, 0, -1,  0, -1);
        run_line(1, 1, 0, 0, -1,  0, -1);
        run_line(1, 1, 0, 0, -1,  0, -1);
        run_line(1, 1, 0, 0, -1,  0, 200);
        run_line(1, 0, 0, 0, -1,  0, -1);
        run_line(1, 0, 0, 0, 96,  0, -1);
        run_line(1, 1, 0, 0, -1,  0, -1);

        @(negedge clk_vid);
        ce_pix   = 1'b0;
        chk_idle = 1'b0;
        repeat (3) @(posedge clk_vid);
        #2;
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/video_cleaner_sync.md
Name: video_cleaner_sync

Overview:
- Parametrised next-generation video output cleaner in the core's video path, between the video generator and the scaler/HDMI output.
- Registers RGB and timing on ce_pix and detects the native polarity of HSync and VSync per line and frame.
- Aligns the VBlank and VSync changes to the horizontal sync leading edge.
- Generates DE, either derived from the blanks or passed through, and optionally zeroes colour outside active video.

Parameters:
- CW, 8, colour component width in bits.
- HCNT_W, 12, width of the per-line HSync high/low duration counters (saturating).
- VCNT_W, 20, width of the per-frame VSync high/low duration counters (saturating).
- USE_DE, 0, 1 = DE_out follows DE_in; 0 = DE_out derived from blanks.
- BLANK_ZERO, 1, 1 = force RGB outputs to 0 when DE is low.
- SYNC_OUT_NEG, 1, 1 = VGA_HS/VGA_VS are active-low; 0 = active-high.

Ports:
- clk_vid, in, 1, video clock.
- reset_n, in, 1, asynchronous active-low reset.
- ce_pix, in, 1, pixel clock enable; all state advances only when it is 1.
- R, in, CW, red component.
- G, in, CW, green component.
- B, in, CW, blue component.
- HSync, in, 1, raw horizontal sync, either polarity.
- VSync, in, 1, raw vertical sync, either polarity.
- HBlank, in, 1, horizontal blank, active-high.
- VBlank, in, 1, vertical blank, active-high.
- DE_in, in, 1, external data enable (used when USE_DE=1).
- VGA_R, out, CW, cleaned red.
- VGA_G, out, CW, cleaned green.
- VGA_B, out, CW, cleaned blue.
- VGA_HS, out, 1, normalised horizontal sync (polarity per SYNC_OUT_NEG).
- VGA_VS, out, 1, normalised vertical sync, line-aligned.
- VGA_DE, out, 1, data enable, identical to DE_out.
- HBlank_out, out, 1, registered HBlank.
- VBlank_out, out, 1, line-aligned VBlank.
- DE_out, out, 1, data enable.
- hs_pol, out, 1, detected HSync polarity (1 = input active-low).
- vs_pol, out, 1, detected VSync polarity (1 = input active-low).

Behaviour:
- Reset (reset_n=0, asynchronous):
  - Colour outputs 0; HBlank_out=VBlank_out=1; DE_out=VGA_DE=0.
  - VGA_HS/VGA_VS at their inactive level (1 if SYNC_OUT_NEG=1).
  - hs_pol=vs_pol=0; all counters and edge registers 0.
  - Reset mid-frame discards the detection state; polarity is relearned from the next complete line/frame.
- No register changes on cycles with ce_pix=0. All outputs have a latency of exactly one ce_pix cycle.
- HSync polarity detection:
  - Each ce_pix, increment hcnt_hi if HSync=1, else hcnt_lo. Both counters saturate at 2^HCNT_W-1.
  - On a raw HSync rising edge (HSync=1, previous HSync sample=0): hs_pol <= (hcnt_hi > hcnt_lo), using counts before this sample. Then both counters clear, and the current sample is counted.
  - Equal counts give hs_pol=0.
- VSync polarity detection: identical scheme on VSync with vcnt_hi/vcnt_lo (VCNT_W), updating vs_pol on raw VSync rising edges.
- Normalised active-high internal syncs: hs_n = HSync ^ hs_pol; vs_n = VSync ^ vs_pol. The polarity values used are the register values before this cycle's update.
- Line alignment: hs_lead = hs_n=1 and previous hs_n=0.
  - On hs_lead: VBlank_out <= VBlank and the internal vs_a <= vs_n.
  - Otherwise VBlank_out and vs_a hold.
  - VBlank or VSync toggling mid-line appears at the next HSync leading edge, in the same cycle as VGA_HS becomes active.
- Horizontal path: HBlank_out <= HBlank. VGA_HS <= hs_n, inverted when SYNC_OUT_NEG=1. VGA_VS <= vs_a (next value), inverted likewise.
- DE:
  - USE_DE=1: DE_out <= DE_in.
  - USE_DE=0: DE_out <= ~(HBlank | vblank_next), where vblank_next is the value VBlank_out takes this cycle. VGA_DE mirrors DE_out.
- Colour: VGA_R/G/B <= 0 when BLANK_ZERO=1 and the next DE value is 0; otherwise <= R/G/B.
- Simultaneous events: if a polarity update and hs_lead occur in the same ce_pix, hs_lead uses the old polarity. The new polarity takes effect from the next ce_pix. A one-cycle sync glitch at a polarity flip is accepted.
- Counter saturation: comparison still valid; both saturated gives hs_pol=0.

Test Plan:
- Reset: hold reset_n=0 with random inputs -> VGA_R/G/B=0, VGA_HS=VGA_VS=1, HBlank_out=VBlank_out=1, DE_out=0, hs_pol=vs_pol=0; release, one ce_pix with R=8'h5A, blanks 0, polarity pattern not yet learned -> VGA_R=8'h5A, DE_out=1.
- Polarity learn: 800-pixel lines, HSync low 96 / high 704 (active-low) -> hs_pol=1 after the second rising edge; VGA_HS low during exactly the 96 pulse pixels, delayed one ce_pix. Repeat with 96 high / 704 low -> hs_pol=0, same VGA_HS output.
- ce_pix gating: ce_pix toggling every 4th clk_vid -> outputs change only one clk after a ce_pix=1 cycle; counters count 800 per line, not 3200.
- VBlank alignment: raise VBlank at pixel 300 of line 10 -> VBlank_out rises on line 11 in the same cycle VGA_HS goes active; DE_out stays 0 from then on.
- Blank zeroing: BLANK_ZERO=1, HBlank=1, R=G=B=8'hFF -> VGA_R/G/B=0, DE_out=0. With BLANK_ZERO=0 -> 8'hFF. USE_DE=1, DE_in=1, HBlank=1 -> DE_out=1.
- Mid-frame reset: assert reset_n=0 at line 5, pixel 200 -> all outputs return to reset values immediately (asynchronously); after release, hs_pol re-detected after two full lines.
